// File: rtl/ahb_mtx_pkg.sv
// Shared AHB bus-matrix definitions: transfer/burst encodings, arbitration modes and
// the fixed-length burst beat count helper.
package ahb_mtx_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;
  localparam int BEAT_W    = 4;

  // Beats remaining after the first beat; zero for SINGLE and undefined-length INCR.
  function automatic logic [BEAT_W-1:0] beats_m1(input logic [2:0] hburst);
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  beats_m1 = 4'd3;
      HBURST_WRAP8,  HBURST_INCR8:  beats_m1 = 4'd7;
      HBURST_WRAP16, HBURST_INCR16: beats_m1 = 4'd15;
      default:                      beats_m1 = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_mtx_arb_burst_cnt.sv
// Tracks beats remaining in the current fixed-length burst on one slave output and
// decodes whether the arbiter must keep its current grant.
module ahb_mtx_arb_burst_cnt
  import ahb_mtx_pkg::*;
#(
  parameter int BURST_HOLD = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_hready,
  input  logic       i_hsel,
  input  logic [1:0] i_htrans,
  input  logic [2:0] i_hburst,
  output logic       o_burst_hold
);

  logic [BEAT_W-1:0] r_beat_cnt;
  logic [BEAT_W-1:0] w_beat_cnt_next;
  logic              w_hold_cond;

  // A NONSEQ always reloads, so a new burst cleanly terminates an unfinished one.
  always_comb begin
    w_beat_cnt_next = r_beat_cnt;
    case (i_htrans)
      HTRANS_NONSEQ: w_beat_cnt_next = beats_m1(i_hburst);
      HTRANS_SEQ:    if (r_beat_cnt != '0) w_beat_cnt_next = r_beat_cnt - BEAT_W'(1);
      HTRANS_IDLE:   w_beat_cnt_next = '0;
      default:       w_beat_cnt_next = r_beat_cnt;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_beat_cnt <= '0;
    end else if (i_hready) begin
      r_beat_cnt <= w_beat_cnt_next;
    end
  end

  always_comb begin
    w_hold_cond = 1'b0;
    case (i_htrans)
      HTRANS_NONSEQ: w_hold_cond = (beats_m1(i_hburst) != '0);
      HTRANS_SEQ:    w_hold_cond = (r_beat_cnt > BEAT_W'(1));
      HTRANS_BUSY:   w_hold_cond = (r_beat_cnt != '0);
      default:       w_hold_cond = 1'b0;
    endcase
  end

  assign o_burst_hold = (BURST_HOLD != 0) && i_hsel && w_hold_cond;

endmodule

// File: rtl/ahb_mtx_arb_param.sv
// Per-slave output-stage arbiter: selects which input port owns the next address phase,
// with fixed-priority or round-robin selection, lock and fixed-burst grant protection.
module ahb_mtx_arb_param
  import ahb_mtx_pkg::*;
#(
  parameter int                   NUM_PORTS  = 8,
  parameter int                   ADDR_W     = 3,
  parameter logic [NUM_PORTS-1:0] PORT_MASK  = '1,
  parameter int                   ARB_MODE   = ARB_FIXED,
  parameter int                   BURST_HOLD = 1
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [NUM_PORTS-1:0] req_port,
  input  logic                 HREADYM,
  input  logic                 HSELM,
  input  logic [1:0]           HTRANSM,
  input  logic [2:0]           HBURSTM,
  input  logic                 HMASTLOCKM,
  output logic [ADDR_W-1:0]    addr_in_port,
  output logic                 no_port,
  output logic [NUM_PORTS-1:0] sel_onehot
);

  logic [ADDR_W-1:0]    r_addr, w_addr_next;
  logic                 r_no_port, w_no_port_next;
  logic [ADDR_W-1:0]    r_rr_last, w_rr_last_next;
  logic                 w_burst_hold;
  logic                 w_active;
  logic [NUM_PORTS-1:0] w_elig;

  logic [NUM_PORTS:0]   w_fx_found;
  logic [ADDR_W-1:0]    w_fx_idx [NUM_PORTS+1];
  logic [NUM_PORTS:0]   w_rr_found;
  logic [ADDR_W-1:0]    w_rr_idx [NUM_PORTS+1];
  logic [ADDR_W:0]      w_rr_sum [NUM_PORTS];
  logic [ADDR_W-1:0]    w_rr_cand [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_rr_hit;
  logic                 w_any;
  logic [ADDR_W-1:0]    w_win;

  ahb_mtx_arb_burst_cnt #(
    .BURST_HOLD (BURST_HOLD)
  ) u_burst_cnt (
    .i_clk        (HCLK),
    .i_rst_n      (HRESETn),
    .i_hready     (HREADYM),
    .i_hsel       (HSELM),
    .i_htrans     (HTRANSM),
    .i_hburst     (HBURSTM),
    .o_burst_hold (w_burst_hold)
  );

  // The current owner stays eligible while its transfer is still active, even if it
  // has already dropped its request line.
  assign w_active = HSELM && (HTRANSM != HTRANS_IDLE);

  assign w_fx_found[0] = 1'b0;
  assign w_fx_idx[0]   = '0;
  assign w_rr_found[0] = 1'b0;
  assign w_rr_idx[0]   = '0;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign w_elig[gi] = PORT_MASK[gi] &&
                        (req_port[gi] || (w_active && (r_addr == ADDR_W'(gi))));

    assign w_fx_found[gi+1] = w_fx_found[gi] || w_elig[gi];
    assign w_fx_idx[gi+1]   = w_fx_found[gi] ? w_fx_idx[gi] : ADDR_W'(gi);

    // Candidate gi is the (gi+1)-th port after the last winner, wrapping at NUM_PORTS.
    assign w_rr_sum[gi]  = {1'b0, r_rr_last} + (ADDR_W+1)'(gi + 1);
    assign w_rr_cand[gi] = ADDR_W'((w_rr_sum[gi] >= (ADDR_W+1)'(NUM_PORTS)) ?
                                   (w_rr_sum[gi] - (ADDR_W+1)'(NUM_PORTS)) : w_rr_sum[gi]);
    assign w_rr_hit[gi]  = |(w_elig & (NUM_PORTS'(1) << w_rr_cand[gi]));

    assign w_rr_found[gi+1] = w_rr_found[gi] || w_rr_hit[gi];
    assign w_rr_idx[gi+1]   = w_rr_found[gi] ? w_rr_idx[gi] : w_rr_cand[gi];

    assign sel_onehot[gi] = !r_no_port && (r_addr == ADDR_W'(gi));
  end

  assign w_any = (ARB_MODE == ARB_RR) ? w_rr_found[NUM_PORTS] : w_fx_found[NUM_PORTS];
  assign w_win = (ARB_MODE == ARB_RR) ? w_rr_idx[NUM_PORTS]   : w_fx_idx[NUM_PORTS];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_addr    <= '0;
      r_no_port <= 1'b1;
      r_rr_last <= ADDR_W'(NUM_PORTS - 1);
    end else if (HREADYM) begin
      r_addr    <= w_addr_next;
      r_no_port <= w_no_port_next;
      r_rr_last <= w_rr_last_next;
    end
  end

  always_comb begin
    w_addr_next    = r_addr;
    w_no_port_next = r_no_port;
    w_rr_last_next = r_rr_last;
    if (!(HMASTLOCKM || w_burst_hold)) begin
      if (w_any) begin
        w_addr_next    = w_win;
        w_no_port_next = 1'b0;
        w_rr_last_next = w_win;
      end else if (HSELM) begin
        w_no_port_next = 1'b0;
      end else begin
        w_no_port_next = 1'b1;
      end
    end
  end

  assign addr_in_port = r_addr;
  assign no_port      = r_no_port;

endmodule
